input_debouncer: RTL and testbench
==================================

// Module: input_debouncer
// PURPOSE
//   Conditions a raw asynchronous input (switch/pin) into a clean, glitch-free level
//   for the downstream edge detector. The edge detector's 'a' input is fed by a_clean.
//   Two stages do this: a flop synchroniser, then a stability-qualification FSM.
//   A saturating counter reports rejected glitches for debug.
// PARAMETERS
//   SYNC_STAGES   2  synchroniser depth in flops; legal range 2..4
//   STABLE_CYCLES 4  consecutive synced samples needed to accept a new level; legal range 2..2^CNT_W-1
//   CNT_W         4  width of the qualification counter
//   GLITCH_W      8  width of glitch_cnt (saturating)
// PORTS
//   clk        in   1         single clock, all flops rising-edge
//   reset      in   1         synchronous, active-high
//   a_raw      in   1         raw asynchronous input
//   a_clean    out  1         debounced level, registered; drives edge detector 'a'
//   busy       out  1         1 while a level change is being qualified
//   glitch_cnt out  GLITCH_W  number of rejected transitions, saturating
// BEHAVIOUR
//   Reset (sampled at a clk edge with reset=1):
//     - sync chain = 0, state = STABLE_LOW, cnt = 0
//     - a_clean = 0, busy = 0, glitch_cnt = 0
//     - reset wins over every other event and aborts any qualification in progress
//   Synchroniser:
//     - a_sync = a_raw delayed by SYNC_STAGES edges
//     - no logic between the sync flops
//   FSM states: STABLE_LOW, QUAL_HIGH, STABLE_HIGH, QUAL_LOW
//     - STABLE_LOW:  a_sync=1 -> QUAL_HIGH, cnt=1; else stay
//     - QUAL_HIGH:   a_sync=0 -> STABLE_LOW, glitch_cnt+1
//                    a_sync=1, cnt==STABLE_CYCLES-1 -> STABLE_HIGH, a_clean=1, cnt=0
//                    a_sync=1, otherwise -> cnt+1
//     - STABLE_HIGH / QUAL_LOW: mirror of the two states above with polarity inverted
//   Outputs:
//     - a_clean changes only on entry to STABLE_LOW or STABLE_HIGH from a QUAL state
//     - busy = 1 exactly when state is QUAL_HIGH or QUAL_LOW (registered alongside state)
//   Latency:
//     - a_raw first sampled high at edge k and held: a_clean=1 after edge k+SYNC_STAGES+STABLE_CYCLES-1
//     - defaults: edge k+5; falling edge symmetric
//   Glitch rules:
//     - a_sync must hold for STABLE_CYCLES consecutive edges; any shorter run is rejected
//     - a_clean never toggles on a rejected run
//     - glitch_cnt holds at 2^GLITCH_W-1, no wrap
//   Counter:
//     - cnt never exceeds STABLE_CYCLES-1
//     - cnt is cleared on every return to a STABLE state
//   Illegal state encoding -> STABLE_LOW with a_clean=0
// TESTING
//   1. Reset 2 cycles, a_raw=0 for 10 cycles -> a_clean=0, busy=0, glitch_cnt=0 throughout
//   2. a_raw 0->1 sampled at edge k, held 10 cycles -> a_clean=1 after edge k+5 (not k+4);
//      busy=1 after edges k+2..k+4, 0 after k+5
//   3. a_raw high for 2 cycles, then low -> a_clean stays 0, glitch_cnt=1, busy returns to 0
//   4. From a_clean=1: a_raw low for 3 cycles, then high -> a_clean stays 1, glitch_cnt+1;
//      then low held 6 cycles -> a_clean=0 five edges after the first low sample
//   5. GLITCH_W=2: five 1-cycle pulses, 8 cycles apart -> glitch_cnt = 1,2,3,3,3
//   6. reset=1 while in QUAL_HIGH with cnt=2 -> after that edge a_clean=0, busy=0, glitch_cnt=0;
//      a_raw still high after release -> full 5-edge qualification restarts

Source files
------------

// File: rtl/input_debouncer.sv
// Synchroniser plus stability-qualification FSM that turns a raw pin into a clean level.
// Latency SYNC_STAGES+STABLE_CYCLES-1 edges per accepted change; no backpressure, so runs shorter than STABLE_CYCLES are dropped and counted.
module input_debouncer #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 4,
    parameter int GLITCH_W      = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                a_raw,
    output logic                a_clean,
    output logic                busy,
    output logic [GLITCH_W-1:0] glitch_cnt
);

    typedef enum logic [1:0] {
        STABLE_LOW  = 2'd0,
        QUAL_HIGH   = 2'd1,
        STABLE_HIGH = 2'd2,
        QUAL_LOW    = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                  w_a_sync;
    logic [CNT_W-1:0]      r_cnt;
    logic [CNT_W-1:0]      w_cnt_nxt;
    logic                  r_clean;
    logic                  w_clean_nxt;
    logic                  r_busy;
    logic [GLITCH_W-1:0]   r_glitch;
    logic                  w_reject;

    // Plain shift chain: nothing may sit between these flops.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], a_raw};
        end
    end

    assign w_a_sync = r_sync[SYNC_STAGES-1];

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_clean_nxt = r_clean;
        w_reject    = 1'b0;
        case (r_state)
            STABLE_LOW: begin
                if (w_a_sync) begin
                    w_state_nxt = QUAL_HIGH;
                    w_cnt_nxt   = CNT_ONE;
                end
            end
            QUAL_HIGH: begin
                if (!w_a_sync) begin
                    w_state_nxt = STABLE_LOW;
                    w_cnt_nxt   = '0;
                    w_reject    = 1'b1;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = STABLE_HIGH;
                    w_cnt_nxt   = '0;
                    w_clean_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            STABLE_HIGH: begin
                if (!w_a_sync) begin
                    w_state_nxt = QUAL_LOW;
                    w_cnt_nxt   = CNT_ONE;
                end
            end
            QUAL_LOW: begin
                if (w_a_sync) begin
                    w_state_nxt = STABLE_HIGH;
                    w_cnt_nxt   = '0;
                    w_reject    = 1'b1;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = STABLE_LOW;
                    w_cnt_nxt   = '0;
                    w_clean_nxt = 1'b0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = STABLE_LOW;
                w_cnt_nxt   = '0;
                w_clean_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= STABLE_LOW;
            r_cnt    <= '0;
            r_clean  <= 1'b0;
            r_busy   <= 1'b0;
            r_glitch <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_clean <= w_clean_nxt;
            r_busy  <= (w_state_nxt == QUAL_HIGH) || (w_state_nxt == QUAL_LOW);
            if (w_reject && (r_glitch != {GLITCH_W{1'b1}})) begin
                r_glitch <= r_glitch + 1'b1;
            end
        end
    end

    assign a_clean    = r_clean;
    assign busy       = r_busy;
    assign glitch_cnt = r_glitch;

endmodule

// File: tb/tb_input_debouncer.sv
// Bench for input_debouncer: default instance plus a GLITCH_W=2 instance on shared inputs,
// checked against a run-length reference model and the scenario timings.
module tb_input_debouncer;

    localparam int SYNC = 2;
    localparam int STAB = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       a_raw = 1'b0;
    logic       a_clean, busy;
    logic [7:0] glitch_cnt;
    logic       a_clean2, busy2;
    logic [1:0] glitch_cnt2;

    int tests = 0;
    int fails = 0;

    bit m_q[$];
    bit m_clean;
    int m_run;
    int m_glitch;
    int edge_n = 0;

    input_debouncer dut (
        .clk(clk), .reset(reset), .a_raw(a_raw),
        .a_clean(a_clean), .busy(busy), .glitch_cnt(glitch_cnt)
    );

    input_debouncer #(.GLITCH_W(2)) dut_g2 (
        .clk(clk), .reset(reset), .a_raw(a_raw),
        .a_clean(a_clean2), .busy(busy2), .glitch_cnt(glitch_cnt2)
    );

    always #5 clk = ~clk;

    // Model: the FSM sees the raw sample from SYNC edges ago; a run of the opposite
    // level is accepted once it reaches STAB samples, and a shorter run is a glitch.
    task automatic step(input logic rst, input logic raw);
        bit s;
        reset = rst;
        a_raw = raw;
        @(posedge clk);
        edge_n++;
        if (rst) begin
            m_q = {};
            repeat (SYNC) m_q.push_back(1'b0);
            m_clean  = 1'b0;
            m_run    = 0;
            m_glitch = 0;
        end else begin
            s = m_q.pop_front();
            m_q.push_back(raw);
            if (s != m_clean) begin
                m_run++;
                if (m_run == STAB) begin
                    m_clean = s;
                    m_run   = 0;
                end
            end else if (m_run > 0) begin
                m_glitch++;
                m_run = 0;
            end
        end
        #1;
    endtask

    function automatic logic [11:0] exp_vec();
        int e8, e2;
        e8 = (m_glitch > 255) ? 255 : m_glitch;
        e2 = (m_glitch > 3) ? 3 : m_glitch;
        return {m_clean, (m_run > 0), 8'(e8), 2'(e2)};
    endfunction

    task automatic test_reset();
        logic [11:0] obs;
        repeat (2) step(1'b1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0);
            obs = {a_clean, busy, glitch_cnt, glitch_cnt2};
            tests++;
            if (obs !== 12'h000) begin
                fails++;
                $display("FAIL reset_idle edge=%0d got=%h exp=000", edge_n, obs);
            end
        end
    endtask

    task automatic test_rise();
        logic [11:0] obs;
        logic [11:0] ex;
        repeat (2) step(1'b1, 1'b0);
        repeat (3) step(1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b1);
            obs = {a_clean, busy, glitch_cnt, glitch_cnt2};
            ex  = {(i >= 5) ? 1'b1 : 1'b0, (i >= 2 && i <= 4) ? 1'b1 : 1'b0, 10'd0};
            tests++;
            if (obs !== ex) begin
                fails++;
                $display("FAIL rise_timing k+%0d got=%h exp=%h", i, obs, ex);
            end
            tests++;
            if (obs !== exp_vec()) begin
                fails++;
                $display("FAIL rise_model edge=%0d got=%h exp=%h", edge_n, obs, exp_vec());
            end
        end
    endtask

    task automatic test_short_pulse();
        repeat (2) step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b0);
            tests++;
            if (a_clean !== 1'b0) begin
                fails++;
                $display("FAIL pulse_clean edge=%0d got=%b exp=0", edge_n, a_clean);
            end
        end
        tests++;
        if ({busy, glitch_cnt} !== {1'b0, 8'd1}) begin
            fails++;
            $display("FAIL pulse_glitch got busy=%b cnt=%0d exp busy=0 cnt=1", busy, glitch_cnt);
        end
    endtask

    task automatic test_fall();
        repeat (2) step(1'b1, 1'b0);
        repeat (8) step(1'b0, 1'b1);
        tests++;
        if (a_clean !== 1'b1) begin
            fails++;
            $display("FAIL fall_setup got=%b exp=1", a_clean);
        end
        repeat (3) step(1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b1);
            tests++;
            if (a_clean !== 1'b1) begin
                fails++;
                $display("FAIL fall_reject edge=%0d got=%b exp=1", edge_n, a_clean);
            end
        end
        tests++;
        if (glitch_cnt !== 8'd1) begin
            fails++;
            $display("FAIL fall_glitch got=%0d exp=1", glitch_cnt);
        end
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b0);
            tests++;
            if (a_clean !== ((i >= 5) ? 1'b0 : 1'b1)) begin
                fails++;
                $display("FAIL fall_timing j+%0d got=%b exp=%b", i, a_clean, (i < 5));
            end
        end
    endtask

    task automatic test_glitch_sat();
        repeat (2) step(1'b1, 1'b0);
        for (int n = 1; n <= 5; n++) begin
            step(1'b0, 1'b1);
            repeat (7) step(1'b0, 1'b0);
            tests++;
            if (glitch_cnt2 !== 2'((n > 3) ? 3 : n) || glitch_cnt !== 8'(n)) begin
                fails++;
                $display("FAIL glitch_sat pulse=%0d got w2=%0d w8=%0d exp w2=%0d w8=%0d",
                         n, glitch_cnt2, glitch_cnt, (n > 3) ? 3 : n, n);
            end
        end
    endtask

    task automatic test_reset_mid();
        repeat (2) step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        repeat (7) step(1'b0, 1'b0);
        repeat (4) step(1'b0, 1'b1);
        tests++;
        if ({busy, glitch_cnt} !== {1'b1, 8'd1}) begin
            fails++;
            $display("FAIL reset_mid_setup got busy=%b cnt=%0d exp busy=1 cnt=1", busy, glitch_cnt);
        end
        step(1'b1, 1'b1);
        tests++;
        if ({a_clean, busy, glitch_cnt} !== 10'd0) begin
            fails++;
            $display("FAIL reset_mid_clear got clean=%b busy=%b cnt=%0d exp 0/0/0",
                     a_clean, busy, glitch_cnt);
        end
        for (int i = 0; i < 7; i++) begin
            step(1'b0, 1'b1);
            tests++;
            if ({a_clean, busy} !== {(i >= 5) ? 1'b1 : 1'b0, (i >= 2 && i <= 4) ? 1'b1 : 1'b0}) begin
                fails++;
                $display("FAIL reset_mid_restart r+%0d got clean=%b busy=%b", i, a_clean, busy);
            end
        end
    endtask

    task automatic test_random();
        logic [11:0] obs;
        logic        lvl;
        int          len;
        repeat (2) step(1'b1, 1'b0);
        lvl = 1'b0;
        for (int r = 0; r < 150; r++) begin
            lvl = ~lvl;
            len = $urandom_range(1, 7);
            for (int j = 0; j < len; j++) begin
                step(($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0, lvl);
                obs = {a_clean, busy, glitch_cnt, glitch_cnt2};
                tests++;
                if (obs !== exp_vec()) begin
                    fails++;
                    $display("FAIL random_model edge=%0d got=%h exp=%h", edge_n, obs, exp_vec());
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_rise();
        test_short_pulse();
        test_fall();
        test_glitch_sat();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
